// File: rtl/multi_cycle_processor.sv
// Multi-cycle MIPS subset core with one shared memory port and a ready handshake.
// Each instruction walks FETCH/DECODE/EXEC/MEM/WB. Illegal or misaligned work parks the core in HALT.
module multi_cycle_processor #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    logic [2:0]        stateReg, stateNext;
    logic [31:0]       pcReg, pcNext;
    logic [31:0]       irReg, irNext;
    logic [31:0]       aReg, aNext;
    logic [31:0]       bReg, bNext;
    logic [31:0]       targetReg, targetNext;
    logic [31:0]       aluOutReg, aluOutNext;
    logic [31:0]       mdrReg, mdrNext;
    logic              memReqReg, memReqNext;
    logic              memWeReg, memWeNext;
    logic [ADDR_W-1:0] memAddrReg, memAddrNext;
    logic [31:0]       memWdataReg, memWdataNext;

    logic [31:0] regFile [32];
    logic        regWe;
    logic [4:0]  regWaddr;
    logic [31:0] regWdata;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] immSext, rsVal, rtVal, aluResult;
    logic        isRType, legalOp, enterFetch, handshake;

    assign opcode    = irReg[31:26];
    assign rs        = irReg[25:21];
    assign rt        = irReg[20:16];
    assign rd        = irReg[15:11];
    assign funct     = irReg[5:0];
    assign immSext   = {{16{irReg[15]}}, irReg[15:0]};
    assign isRType   = (opcode == OP_RTYPE);
    assign rsVal     = (rs == 5'd0) ? 32'd0 : regFile[rs];
    assign rtVal     = (rt == 5'd0) ? 32'd0 : regFile[rt];
    assign handshake = memReqReg && mem_ready;

    always_comb begin
        case (opcode)
            OP_RTYPE: legalOp = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legalOp = 1'b1;
            default: legalOp = 1'b0;
        endcase
    end

    // Non-R-type users of the ALU (addi/lw/sw) all want A + sext(imm).
    always_comb begin
        aluResult = aReg + immSext;
        if (isRType) begin
            case (funct)
                F_SUB:   aluResult = aReg - bReg;
                F_AND:   aluResult = aReg & bReg;
                F_OR:    aluResult = aReg | bReg;
                F_SLT:   aluResult = {31'd0, $signed(aReg) < $signed(bReg)};
                default: aluResult = aReg + bReg;
            endcase
        end
    end

    always_comb begin
        stateNext    = stateReg;
        pcNext       = pcReg;
        irNext       = irReg;
        aNext        = aReg;
        bNext        = bReg;
        targetNext   = targetReg;
        aluOutNext   = aluOutReg;
        mdrNext      = mdrReg;
        memReqNext   = memReqReg;
        memWeNext    = memWeReg;
        memAddrNext  = memAddrReg;
        memWdataNext = memWdataReg;
        regWe        = 1'b0;
        regWaddr     = isRType ? rd : rt;
        regWdata     = (opcode == OP_LW) ? mdrReg : aluOutReg;
        retire       = 1'b0;
        enterFetch   = 1'b0;
        case (stateReg)
            S_FETCH: begin
                if (!memReqReg) begin
                    memReqNext = 1'b1;   // idle cycle right after reset
                end else if (handshake) begin
                    irNext     = mem_rdata;
                    pcNext     = pcReg + 32'd4;
                    stateNext  = S_DECODE;
                    memReqNext = 1'b0;
                end
            end
            S_DECODE: begin
                aNext      = rsVal;
                bNext      = rtVal;
                targetNext = pcReg + (immSext << 2);
                if (opcode == OP_J) begin
                    pcNext     = {pcReg[31:28], irReg[25:0], 2'b00};
                    retire     = 1'b1;
                    enterFetch = 1'b1;
                end else if (!legalOp) begin
                    stateNext = S_HALT;
                end else begin
                    stateNext = S_EXEC;
                end
            end
            S_EXEC: begin
                aluOutNext = aluResult;
                if (opcode == OP_BEQ) begin
                    if (aReg == bReg) pcNext = targetReg;
                    retire     = 1'b1;
                    enterFetch = 1'b1;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    if (aluResult[1:0] != 2'b00) begin
                        stateNext = S_HALT;
                    end else begin
                        stateNext    = S_MEM;
                        memReqNext   = 1'b1;
                        memWeNext    = (opcode == OP_SW);
                        memAddrNext  = aluResult[ADDR_W-1:0];
                        memWdataNext = (opcode == OP_SW) ? bReg : 32'd0;
                    end
                end else begin
                    stateNext = S_WB;
                end
            end
            S_MEM: begin
                if (handshake) begin
                    if (opcode == OP_SW) begin
                        retire     = 1'b1;
                        enterFetch = 1'b1;
                    end else begin
                        mdrNext    = mem_rdata;
                        stateNext  = S_WB;
                        memReqNext = 1'b0;
                    end
                end
            end
            S_WB: begin
                regWe      = 1'b1;
                retire     = 1'b1;
                enterFetch = 1'b1;
            end
            S_HALT: begin
                memReqNext   = 1'b0;
                memWeNext    = 1'b0;
                memWdataNext = 32'd0;
            end
            default: stateNext = S_HALT;
        endcase
        // Fetch request is issued in the same edge that leaves the finishing state.
        if (enterFetch) begin
            stateNext    = S_FETCH;
            memReqNext   = 1'b1;
            memWeNext    = 1'b0;
            memAddrNext  = pcNext[ADDR_W-1:0];
            memWdataNext = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= S_FETCH;
            pcReg       <= RESET_PC;
            irReg       <= 32'd0;
            aReg        <= 32'd0;
            bReg        <= 32'd0;
            targetReg   <= 32'd0;
            aluOutReg   <= 32'd0;
            mdrReg      <= 32'd0;
            memReqReg   <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= RESET_PC[ADDR_W-1:0];
            memWdataReg <= 32'd0;
        end else begin
            stateReg    <= stateNext;
            pcReg       <= pcNext;
            irReg       <= irNext;
            aReg        <= aNext;
            bReg        <= bNext;
            targetReg   <= targetNext;
            aluOutReg   <= aluOutNext;
            mdrReg      <= mdrNext;
            memReqReg   <= memReqNext;
            memWeReg    <= memWeNext;
            memAddrReg  <= memAddrNext;
            memWdataReg <= memWdataNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regFile[i] <= 32'd0;
        end else if (regWe && regWaddr != 5'd0) begin
            regFile[regWaddr] <= regWdata;
        end
    end

    assign mem_req   = memReqReg;
    assign mem_we    = memWeReg;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = memWdataReg;
    assign halted    = (stateReg == S_HALT);
    // Outside FETCH the PC already points past the instruction in flight.
    assign pc_out    = (stateReg == S_FETCH) ? pcReg[ADDR_W-1:0]
                                             : pcReg[ADDR_W-1:0] - ADDR_W'(4);

endmodule

// File: tb/tb_multi_cycle_processor.sv
// Directed bench for multi_cycle_processor: small programs in a latency-configurable word memory,
// with writes, reads and retire times logged and compared against hand-computed values.
module tb_multi_cycle_processor;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          AW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req, mem_we, retire, halted;
    logic [AW-1:0] mem_addr, pc_out;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;
    logic          mem_ready = 1'b0;

    logic [31:0] mem [256];
    int          latency = 0;
    int          waitCnt = 0;
    int          cycleCnt = 0;
    int          totalCnt = 0;
    int          badCnt = 0;
    logic [31:0] wrAddrQ[$], wrDataQ[$], rdAddrQ[$], retireQ[$];

    always #5 clk = ~clk;

    multi_cycle_processor #(.RESET_PC(RPC), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .retire(retire), .halted(halted)
    );

    // Memory answers `latency` cycles after a request appears; a fresh count starts after each completion.
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ready = 1'b0;
            waitCnt   = 0;
        end else begin
            if (mem_ready) waitCnt = 0;
            mem_ready = (waitCnt >= latency);
            waitCnt++;
        end
        mem_rdata = mem[mem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (rst_n) begin
            cycleCnt++;
            if (retire) retireQ.push_back(32'(cycleCnt));
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    wrAddrQ.push_back(32'(mem_addr));
                    wrDataQ.push_back(mem_wdata);
                    $display("  write addr=%h data=%h", mem_addr, mem_wdata);
                end else begin
                    rdAddrQ.push_back(32'(mem_addr));
                end
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rIns(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] iIns(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic enterReset();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic startRun(input int lat);
        latency = lat;
        repeat (2) @(negedge clk);
        wrAddrQ.delete(); wrDataQ.delete(); rdAddrQ.delete(); retireQ.delete();
        cycleCnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic waitHalt();
        for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    endtask

    initial begin
        // ---- ALU program, zero-wait memory ----
        enterReset();
        mem[8'h40] = iIns(6'b001000, 0, 1, 5);          // addi $1,$0,5
        mem[8'h41] = iIns(6'b001000, 0, 2, -3);         // addi $2,$0,-3
        mem[8'h42] = rIns(1, 2, 3, 6'b100000);          // add  $3,$1,$2
        mem[8'h43] = rIns(2, 1, 4, 6'b101010);          // slt  $4,$2,$1
        mem[8'h44] = rIns(2, 1, 5, 6'b100010);          // sub  $5,$2,$1
        mem[8'h45] = iIns(6'b101011, 0, 3, 0);          // sw   $3,0($0)
        mem[8'h46] = iIns(6'b101011, 0, 4, 4);          // sw   $4,4($0)
        mem[8'h47] = iIns(6'b101011, 0, 5, 8);          // sw   $5,8($0)
        mem[8'h48] = iIns(6'b000100, 1, 2, 5);          // beq  $1,$2 (not taken)
        mem[8'h49] = iIns(6'b000100, 1, 1, -1);         // beq  $1,$1,-1 (self loop)
        repeat (2) @(negedge clk);
        checkVal("rst mem_req", 32'(mem_req), 32'd0);
        checkVal("rst mem_we", 32'(mem_we), 32'd0);
        checkVal("rst mem_addr", 32'(mem_addr), 32'h100);
        checkVal("rst mem_wdata", mem_wdata, 32'd0);
        checkVal("rst retire", 32'(retire), 32'd0);
        checkVal("rst halted", 32'(halted), 32'd0);
        checkVal("rst pc_out", 32'(pc_out), 32'h100);
        startRun(0);
        @(negedge clk);
        checkVal("first req", 32'(mem_req), 32'd1);
        checkVal("first addr", 32'(mem_addr), 32'h100);
        checkVal("first we", 32'(mem_we), 32'd0);
        repeat (20) @(negedge clk);
        checkVal("retires in 21 cyc", 32'(retireQ.size()), 32'd5);
        checkVal("5th retire cycle", qAt(retireQ, 4), 32'd21);
        for (int i = 0; i < 100 && wrAddrQ.size() < 3; i++) @(negedge clk);
        checkVal("add addr", qAt(wrAddrQ, 0), 32'h0);
        checkVal("add $3", qAt(wrDataQ, 0), 32'd2);
        checkVal("slt $4", qAt(wrDataQ, 1), 32'd1);
        checkVal("sub addr", qAt(wrAddrQ, 2), 32'h8);
        checkVal("sub $5", qAt(wrDataQ, 2), 32'hFFFF_FFF8);
        repeat (30) @(negedge clk);
        checkVal("beq not taken", qAt(rdAddrQ, 9), 32'h124);
        checkVal("beq taken 1", qAt(rdAddrQ, 10), 32'h124);
        checkVal("beq taken 2", qAt(rdAddrQ, 11), 32'h124);
        checkVal("loop pc_out", 32'(pc_out), 32'h124);
        checkVal("loop halted", 32'(halted), 32'd0);

        // ---- store/load with 3 wait cycles, then misaligned lw ----
        enterReset();
        mem[8'h40] = iIns(6'b001000, 0, 1, 5);          // addi $1,$0,5
        mem[8'h41] = iIns(6'b101011, 0, 1, 8);          // sw   $1,8($0)
        mem[8'h42] = iIns(6'b100011, 0, 6, 8);          // lw   $6,8($0)
        mem[8'h43] = iIns(6'b101011, 0, 6, 12);         // sw   $6,12($0)
        mem[8'h44] = iIns(6'b100011, 0, 7, 2);          // lw   $7,2($0) misaligned
        startRun(3);
        waitHalt();
        checkVal("sw addr", qAt(wrAddrQ, 0), 32'h8);
        checkVal("sw data", qAt(wrDataQ, 0), 32'd5);
        checkVal("lw $6 via sw", qAt(wrDataQ, 1), 32'd5);
        checkVal("addi retire cyc", qAt(retireQ, 0), 32'd8);
        checkVal("sw cycles", qAt(retireQ, 1) - qAt(retireQ, 0), 32'd10);
        checkVal("lw cycles", qAt(retireQ, 2) - qAt(retireQ, 1), 32'd11);
        checkVal("misalign halted", 32'(halted), 32'd1);
        checkVal("misalign no req", 32'(mem_req), 32'd0);
        checkVal("misalign reads", 32'(rdAddrQ.size()), 32'd6);
        repeat (10) @(negedge clk);
        checkVal("halt sticky", 32'(halted), 32'd1);
        checkVal("halt retires", 32'(retireQ.size()), 32'd4);

        // ---- jump, then unsupported funct ----
        enterReset();
        mem[8'h40] = {6'b000010, 26'h44};               // j 0x110
        mem[8'h41] = 32'hFFFF_FFFF;
        mem[8'h44] = iIns(6'b001000, 0, 1, 1);          // addi $1,$0,1
        mem[8'h45] = rIns(0, 0, 0, 6'b000000);          // funct 0 -> illegal
        startRun(0);
        waitHalt();
        checkVal("j retire cyc", qAt(retireQ, 0), 32'd3);
        checkVal("addi retire cyc", qAt(retireQ, 1), 32'd7);
        checkVal("j target fetch", qAt(rdAddrQ, 1), 32'h110);
        checkVal("bad funct fetch", qAt(rdAddrQ, 2), 32'h114);
        checkVal("bad funct reads", 32'(rdAddrQ.size()), 32'd3);
        checkVal("bad funct halted", 32'(halted), 32'd1);

        // ---- unknown opcode halts right after DECODE ----
        enterReset();
        mem[8'h40] = 32'hFC00_0000;
        startRun(0);
        repeat (2) @(negedge clk);
        checkVal("op3f in decode", 32'(halted), 32'd0);
        @(negedge clk);
        checkVal("op3f halted", 32'(halted), 32'd1);

        // ---- reset while a store waits ----
        enterReset();
        mem[8'h40] = iIns(6'b001000, 0, 1, 9);          // addi $1,$0,9
        mem[8'h41] = iIns(6'b101011, 0, 1, 16);         // sw   $1,16($0)
        mem[4]     = 32'h1234_5678;
        startRun(5);
        for (int i = 0; i < 100 && !(mem_req && mem_we); i++) @(negedge clk);
        checkVal("sw wait addr", 32'(mem_addr), 32'h10);
        checkVal("sw wait data", mem_wdata, 32'd9);
        @(negedge clk);
        checkVal("sw hold addr", 32'(mem_addr), 32'h10);
        checkVal("sw hold data", mem_wdata, 32'd9);
        #2 rst_n = 1'b0;
        #1;
        checkVal("async req drop", 32'(mem_req), 32'd0);
        checkVal("async we drop", 32'(mem_we), 32'd0);
        @(negedge clk);
        checkVal("aborted mem", mem[4], 32'h1234_5678);
        checkVal("aborted writes", 32'(wrAddrQ.size()), 32'd0);
        startRun(0);
        @(negedge clk);
        checkVal("restart req", 32'(mem_req), 32'd1);
        checkVal("restart addr", 32'(mem_addr), 32'h100);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
